// File: rtl/ber_counter.sv
`timescale 1ns/1ps
// PRBS7 bit-error-rate counter: HUNT/SYNC/LOCK acquisition, live counters, periodic snapshot reports.
// Latency: an accepted bit shows in the live counters one edge later. DISP_BUSY holds reports back, and periods that elapse meanwhile merge into one.
module ber_counter #(
    parameter int SYNC_LEN      = 16,
    parameter int LOSS_THR      = 8,
    parameter int UPDATE_PERIOD = 2**20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIN_VALID,
    input  logic        DIN,
    input  logic        CLEAR,
    input  logic        DISP_BUSY,
    output logic        DISP_START,
    output logic [57:0] RECV_CNT,
    output logic [63:0] ERR_CNT,
    output logic        LOCKED,
    output logic        OVERFLOW
);
    localparam int MW = $clog2(SYNC_LEN + 1);
    localparam int EW = $clog2(LOSS_THR + 1);
    localparam int PW = $clog2(UPDATE_PERIOD + 1);
    localparam logic [MW-1:0] SYNC_LAST   = MW'(SYNC_LEN - 1);
    localparam logic [EW-1:0] LOSS_LIM    = EW'(LOSS_THR);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(UPDATE_PERIOD - 1);
    localparam logic [57:0]   RECV_MAX    = '1;

    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

    state_t        state, state_nxt;
    logic [6:0]    lfsr, lfsr_nxt;
    logic [2:0]    fill_cnt, fill_nxt;
    logic [MW-1:0] match_cnt, match_nxt;
    logic [6:0]    win_bits, win_bits_nxt;
    logic [EW-1:0] win_errs, win_errs_nxt, err_sum;
    logic [57:0]   live_recv, live_recv_nxt;
    logic [63:0]   live_err, live_err_nxt;
    logic [PW-1:0] period_cnt, period_nxt;
    logic          pend, pend_nxt, ovf_nxt, fire;
    logic          pred, bit_err, count_bit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        lfsr_nxt      = lfsr;
        fill_nxt      = fill_cnt;
        match_nxt     = match_cnt;
        win_bits_nxt  = win_bits;
        win_errs_nxt  = win_errs;
        live_recv_nxt = live_recv;
        live_err_nxt  = live_err;
        period_nxt    = period_cnt;
        pend_nxt      = pend;
        fire          = 1'b0;
        pred          = lfsr[6] ^ lfsr[5];
        bit_err       = DIN ^ pred;
        count_bit     = 1'b0;
        err_sum       = win_errs + EW'(bit_err);
        if (DIN_VALID) begin
            case (state)
                HUNT: begin
                    lfsr_nxt = {lfsr[5:0], DIN};
                    if (fill_cnt == 3'd6) begin
                        state_nxt = SYNC;
                        fill_nxt  = '0;
                        match_nxt = '0;
                    end else begin
                        fill_nxt = fill_cnt + 3'd1;
                    end
                end
                SYNC: begin
                    lfsr_nxt = {lfsr[5:0], DIN};
                    if (bit_err) begin
                        state_nxt = HUNT;
                        fill_nxt  = '0;
                    end else if (match_cnt == SYNC_LAST) begin
                        state_nxt    = LOCK;
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end
                LOCK: begin
                    // The LFSR keeps running through CLEAR so the lock stays aligned.
                    lfsr_nxt  = {lfsr[5:0], pred};
                    count_bit = !CLEAR;
                    if (count_bit) begin
                        if (err_sum == LOSS_LIM) begin
                            state_nxt = HUNT;
                            fill_nxt  = '0;
                        end
                        if (win_bits == 7'd127) begin
                            win_bits_nxt = '0;
                            win_errs_nxt = '0;
                        end else begin
                            win_bits_nxt = win_bits + 7'd1;
                            win_errs_nxt = err_sum;
                        end
                        if (live_recv != RECV_MAX) begin
                            live_recv_nxt = live_recv + 58'd1;
                            live_err_nxt  = live_err + {63'd0, bit_err};
                        end
                        if (period_cnt == PERIOD_LAST) begin
                            period_nxt = '0;
                            pend_nxt   = 1'b1;
                        end else begin
                            period_nxt = period_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        ovf_nxt = OVERFLOW | (live_recv_nxt == RECV_MAX);
        if (CLEAR) begin
            live_recv_nxt = '0;
            live_err_nxt  = '0;
            period_nxt    = '0;
            win_bits_nxt  = '0;
            win_errs_nxt  = '0;
            pend_nxt      = 1'b0;
            ovf_nxt       = 1'b0;
        end else if (pend_nxt && !DISP_BUSY && !DISP_START) begin
            fire     = 1'b1;
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr       <= '0;
            fill_cnt   <= '0;
            match_cnt  <= '0;
            win_bits   <= '0;
            win_errs   <= '0;
            live_recv  <= '0;
            live_err   <= '0;
            period_cnt <= '0;
            pend       <= 1'b0;
            OVERFLOW   <= 1'b0;
            DISP_START <= 1'b0;
            RECV_CNT   <= '0;
            ERR_CNT    <= '0;
        end else begin
            lfsr       <= lfsr_nxt;
            fill_cnt   <= fill_nxt;
            match_cnt  <= match_nxt;
            win_bits   <= win_bits_nxt;
            win_errs   <= win_errs_nxt;
            live_recv  <= live_recv_nxt;
            live_err   <= live_err_nxt;
            period_cnt <= period_nxt;
            pend       <= pend_nxt;
            OVERFLOW   <= ovf_nxt;
            DISP_START <= fire;
            if (fire) begin
                RECV_CNT <= live_recv_nxt;
                ERR_CNT  <= live_err_nxt;
            end
        end
    end

    assign LOCKED = (state == LOCK);
endmodule
